// File: rtl/mux2_arbiter.sv
// Two-requester arbitrated mux with registered grants, select and data output.
// Optional contended-hold timeout enabled by defining MUX2_ARB_TIMEOUT_EN.
module mux2_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               lp_q, lp_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               timeout_hit_s;
    logic               owned_next_s;

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0]         cnt_q, cnt_d;

    // Hold counter restarts on every ownership entry and saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (owned_next_s && (state_d != state_q)) begin
            cnt_d = 8'd0;
        end else if (owned_next_s && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end else if (!owned_next_s) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit_s = (cnt_q == TO_LAST);
`else
    // TIMEOUT has no effect without the hold counter.
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = 8'(TIMEOUT);
    assign timeout_hit_s    = 1'b0;
`endif

    // Next-state arbitration; lp_q=1 means requester 0 wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = lp_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (timeout_hit_s && req1) begin
                    state_d = OWN1;
                end else begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (timeout_hit_s && req0) begin
                    state_d = OWN0;
                end else begin
                    state_d = OWN1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the cycle after the edge, derived from the next state.
    always_comb begin
        owned_next_s = (state_d == OWN0) || (state_d == OWN1);
        lp_d         = lp_q;
        sel_d        = sel_q;
        if (state_d == OWN0) begin
            sel_d = 1'b0;
            if (state_q != OWN0) begin
                lp_d = 1'b0;
            end else begin
                lp_d = lp_q;
            end
        end else if (state_d == OWN1) begin
            sel_d = 1'b1;
            if (state_q != OWN1) begin
                lp_d = 1'b1;
            end else begin
                lp_d = lp_q;
            end
        end else begin
            sel_d = sel_q;
            lp_d  = lp_q;
        end
        if (owned_next_s) begin
            y_d = sel_d ? b : a;
        end else begin
            y_d = y_q;
        end
        y_valid_d = owned_next_s;
        gnt0_d    = (state_d == OWN0);
        gnt1_d    = (state_d == OWN1);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lp_q      <= 1'b1;
            sel_q     <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lp_q      <= lp_d;
            sel_q     <= sel_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter (TIMEOUT=4 instance).
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a, b;
    logic       gnt0, gnt1, sel, y_valid;
    logic [7:0] y;

    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;

    mux2_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a(a), .b(b),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    // Per-cycle invariants: exclusive grants, y_valid tracks any grant.
    always @(negedge clk) begin
        mon_checks = mon_checks + 1;
        if ((gnt0 & gnt1) !== 1'b0 || y_valid !== (gnt0 | gnt1)) begin
            mon_errors = mon_errors + 1;
            $display("FAIL invariant t=%0t gnt0=%b gnt1=%b y_valid=%b", $time, gnt0, gnt1, y_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 8'hFF; b = 8'hEE;
        step(); step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== 12'h000) begin
            errors = errors + 1;
            $display("FAIL reset_state got %h want 000", {gnt0, gnt1, sel, y_valid, y});
        end
    endtask

    task automatic test_grant();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b0; a = 8'hA5; b = 8'h00;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== {4'b1001, 8'hA5}) begin
            errors = errors + 1;
            $display("FAIL first_grant got %h want %h", {gnt0, gnt1, sel, y_valid, y}, {4'b1001, 8'hA5});
        end
        a = 8'h5A;
        step();
        checks = checks + 1;
        if (y !== 8'h5A) begin
            errors = errors + 1;
            $display("FAIL data_follow got %h want 5a", y);
        end
        req0 = 1'b0;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== {4'b0000, 8'h5A}) begin
            errors = errors + 1;
            $display("FAIL release_idle got %h want %h", {gnt0, gnt1, sel, y_valid, y}, {4'b0000, 8'h5A});
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a = 8'h11; b = 8'h22;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y} !== {3'b100, 8'h11}) begin
            errors = errors + 1;
            $display("FAIL tie_first got %h want %h", {gnt0, gnt1, sel, y}, {3'b100, 8'h11});
        end
        req0 = 1'b0;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== {4'b0111, 8'h22}) begin
            errors = errors + 1;
            $display("FAIL handover got %h want %h", {gnt0, gnt1, sel, y_valid, y}, {4'b0111, 8'h22});
        end
        req1 = 1'b0;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== {4'b0010, 8'h22}) begin
            errors = errors + 1;
            $display("FAIL idle_sel_hold got %h want %h", {gnt0, gnt1, sel, y_valid, y}, {4'b0010, 8'h22});
        end
    endtask

    task automatic test_last_owner();
        req0 = 1'b1; req1 = 1'b1; a = 8'h33; b = 8'h44;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, y} !== {2'b10, 8'h33}) begin
            errors = errors + 1;
            $display("FAIL lp_after_own1 got %h want %h", {gnt0, gnt1, y}, {2'b10, 8'h33});
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y} !== {3'b011, 8'h44}) begin
            errors = errors + 1;
            $display("FAIL lp_after_own0 got %h want %h", {gnt0, gnt1, sel, y}, {3'b011, 8'h44});
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a = 8'h55; b = 8'h66;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt0 === 1'b1) held = held + 1;
        end
        checks = checks + 1;
        if (held !== 4) begin
            errors = errors + 1;
            $display("FAIL contended_hold got %0d want 4", held);
        end
`ifdef MUX2_ARB_TIMEOUT_EN
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y} !== {3'b011, 8'h66}) begin
            errors = errors + 1;
            $display("FAIL timeout_switch got %h want %h", {gnt0, gnt1, sel, y}, {3'b011, 8'h66});
        end
        step(); step(); step(); step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y} !== {3'b100, 8'h55}) begin
            errors = errors + 1;
            $display("FAIL timeout_back got %h want %h", {gnt0, gnt1, sel, y}, {3'b100, 8'h55});
        end
`else
        held = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (gnt0 === 1'b1 && gnt1 === 1'b0) held = held + 1;
        end
        checks = checks + 1;
        if (held !== 100) begin
            errors = errors + 1;
            $display("FAIL no_timeout_hold got %0d want 100", held);
        end
`endif
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req1 = 1'b1; b = 8'h3C; a = 8'h00;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y} !== {3'b011, 8'h3C}) begin
            errors = errors + 1;
            $display("FAIL own1_setup got %h want %h", {gnt0, gnt1, sel, y}, {3'b011, 8'h3C});
        end
        rst = 1'b1;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== 12'h000) begin
            errors = errors + 1;
            $display("FAIL mid_grant_reset got %h want 000", {gnt0, gnt1, sel, y_valid, y});
        end
        rst = 1'b0;
        step();
        checks = checks + 1;
        if ({gnt0, gnt1, sel, y_valid, y} !== {4'b0111, 8'h3C}) begin
            errors = errors + 1;
            $display("FAIL post_reset_grant got %h want %h", {gnt0, gnt1, sel, y_valid, y}, {4'b0111, 8'h3C});
        end
        req1 = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a = 8'h00; b = 8'h00;
        test_reset();
        test_grant();
        test_tie_handover();
        test_last_owner();
        test_timeout();
        test_reset_mid_grant();
        @(negedge clk);
        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
